// File: rtl/console_probe.sv
// Power-on sequencer and famiclone detector, clocked by CPU M2.
// Grounds CIRAM control for a fixed window, then classifies the console from PPU /A13 behaviour.
module console_probe #(
  parameter int INIT_CYCLES = 15,
  parameter int SAMPLES     = 3,
  parameter int MISMATCH_TH = 1,
  parameter int TIMEOUT     = 1023,
  parameter int MCNT_W      = 4
) (
  input  logic              m2,
  input  logic              reset_n,
  input  logic              ppu_rd_in,
  input  logic              ppu_a13_in,
  input  logic              ppu_not_a13_in,
  input  logic              rearm,
  output logic              init_active,
  output logic              detect_done,
  output logic              new_dendy,
  output logic [MCNT_W-1:0] mismatch_cnt
);

  localparam int INIT_W = $clog2(INIT_CYCLES + 1);
  localparam int SMP_W  = $clog2(SAMPLES + 1);
  localparam int TMO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(INIT_CYCLES);
  localparam logic [SMP_W-1:0]  SMP_LOAD  = SMP_W'(SAMPLES);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [MCNT_W-1:0] MCNT_MAX  = '1;

  typedef enum logic [1:0] {S_INIT, S_SAMPLE, S_OLD, S_NEW} state_t;

  state_t            state;
  logic [INIT_W-1:0] init_cnt;
  logic [SMP_W-1:0]  lo_cnt, hi_cnt;
  logic [TMO_W-1:0]  tmo_cnt;

  logic              valid, mismatch, complete, timed_out, is_new;
  logic [SMP_W-1:0]  lo_next, hi_next;
  logic [MCNT_W-1:0] mcnt_next;

  // Effect of this edge's sample, so the verdict can include it with no extra cycle.
  // NOTE: every always_comb output gets a default first; a missed path would infer a latch.
  always_comb begin
    valid     = ~ppu_rd_in;
    mismatch  = valid && (ppu_a13_in == ppu_not_a13_in);
    lo_next   = lo_cnt;
    hi_next   = hi_cnt;
    mcnt_next = mismatch_cnt;
    if (mismatch && mismatch_cnt != MCNT_MAX) mcnt_next = mismatch_cnt + 1'b1;
    if (valid && !ppu_a13_in && lo_cnt != '0) lo_next = lo_cnt - 1'b1;
    if (valid &&  ppu_a13_in && hi_cnt != '0) hi_next = hi_cnt - 1'b1;
    complete  = (lo_next == '0) && (hi_next == '0);
    is_new    = 32'(mcnt_next) >= 32'(MISMATCH_TH);
    timed_out = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
  end

  // NOTE: state registers use non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge m2 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_INIT;
      init_cnt     <= INIT_LOAD;
      lo_cnt       <= SMP_LOAD;
      hi_cnt       <= SMP_LOAD;
      tmo_cnt      <= '0;
      mismatch_cnt <= '0;
      init_active  <= 1'b1;
      detect_done  <= 1'b0;
      new_dendy    <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          init_cnt <= init_cnt - 1'b1;
          if (init_cnt == INIT_W'(1)) begin
            state       <= S_SAMPLE;
            init_active <= 1'b0;
          end
        end
        S_SAMPLE, S_OLD, S_NEW: begin
          if (rearm) begin
            // Restart detection; the sample on this edge is thrown away.
            state        <= S_SAMPLE;
            lo_cnt       <= SMP_LOAD;
            hi_cnt       <= SMP_LOAD;
            tmo_cnt      <= '0;
            mismatch_cnt <= '0;
            detect_done  <= 1'b0;
            new_dendy    <= 1'b0;
          end else if (state == S_SAMPLE) begin
            tmo_cnt      <= tmo_cnt + 1'b1;
            lo_cnt       <= lo_next;
            hi_cnt       <= hi_next;
            mismatch_cnt <= mcnt_next;
            if (complete) begin
              state       <= is_new ? S_NEW : S_OLD;
              detect_done <= 1'b1;
              new_dendy   <= is_new;
            end else if (timed_out) begin
              // No verdict in time: assume an old console so CIRAM stays enabled.
              state       <= S_OLD;
              detect_done <= 1'b1;
              new_dendy   <= 1'b0;
            end
          end
        end
        default: begin
          state       <= S_INIT;
          init_cnt    <= INIT_LOAD;
          init_active <= 1'b1;
          detect_done <= 1'b0;
          new_dendy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_console_probe.sv
// Bench for console_probe: two instances (default threshold and threshold 2) share stimulus
// and are compared every edge against a sample-counting reference model.
module tb_console_probe;

  localparam int INIT_CYCLES = 15;
  localparam int SAMPLES     = 3;
  localparam int TIMEOUT     = 1023;
  localparam int MCNT_MAX    = 15;

  logic m2 = 1'b0;
  logic reset_n = 1'b0;
  logic ppu_rd_in = 1'b1, ppu_a13_in = 1'b0, ppu_not_a13_in = 1'b1, rearm = 1'b0;

  logic       init_active0, detect_done0, new_dendy0;
  logic [3:0] mismatch_cnt0;
  logic       init_active1, detect_done1, new_dendy1;
  logic [3:0] mismatch_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 m2 = ~m2;

  console_probe dut0 (
    .m2(m2), .reset_n(reset_n), .ppu_rd_in(ppu_rd_in), .ppu_a13_in(ppu_a13_in),
    .ppu_not_a13_in(ppu_not_a13_in), .rearm(rearm), .init_active(init_active0),
    .detect_done(detect_done0), .new_dendy(new_dendy0), .mismatch_cnt(mismatch_cnt0)
  );

  console_probe #(.MISMATCH_TH(2)) dut1 (
    .m2(m2), .reset_n(reset_n), .ppu_rd_in(ppu_rd_in), .ppu_a13_in(ppu_a13_in),
    .ppu_not_a13_in(ppu_not_a13_in), .rearm(rearm), .init_active(init_active1),
    .detect_done(detect_done1), .new_dendy(new_dendy1), .mismatch_cnt(mismatch_cnt1)
  );

  // Reference model: edges left in power-on, samples seen per A13 level, mismatches, elapsed edges.
  int th[2] = '{1, 2};
  int init_left[2], lo_seen[2], hi_seen[2], mism[2], elapsed[2];
  bit done[2], dendy[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      init_left[i] = INIT_CYCLES;
      lo_seen[i] = 0; hi_seen[i] = 0; mism[i] = 0; elapsed[i] = 0;
      done[i] = 0; dendy[i] = 0;
    end
  endtask

  task automatic model_edge(input bit rd, input bit a13, input bit na13, input bit rm);
    for (int i = 0; i < 2; i++) begin
      if (init_left[i] > 0) begin
        init_left[i]--;
      end else if (rm) begin
        lo_seen[i] = 0; hi_seen[i] = 0; mism[i] = 0; elapsed[i] = 0;
        done[i] = 0; dendy[i] = 0;
      end else if (!done[i]) begin
        elapsed[i]++;
        if (!rd) begin
          if (a13 == na13) mism[i] = (mism[i] + 1 > MCNT_MAX) ? MCNT_MAX : mism[i] + 1;
          if (a13) hi_seen[i] = (hi_seen[i] + 1 > SAMPLES) ? SAMPLES : hi_seen[i] + 1;
          else     lo_seen[i] = (lo_seen[i] + 1 > SAMPLES) ? SAMPLES : lo_seen[i] + 1;
        end
        if (lo_seen[i] == SAMPLES && hi_seen[i] == SAMPLES) begin
          done[i] = 1; dendy[i] = (mism[i] >= th[i]);
        end else if (TIMEOUT != 0 && elapsed[i] >= TIMEOUT) begin
          done[i] = 1; dendy[i] = 0;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " dut0.init_active"},  32'(init_active0),  32'(init_left[0] > 0));
    check({tag, " dut0.detect_done"},  32'(detect_done0),  32'(done[0]));
    check({tag, " dut0.new_dendy"},    32'(new_dendy0),    32'(dendy[0]));
    check({tag, " dut0.mismatch_cnt"}, 32'(mismatch_cnt0), 32'(mism[0]));
    check({tag, " dut1.init_active"},  32'(init_active1),  32'(init_left[1] > 0));
    check({tag, " dut1.detect_done"},  32'(detect_done1),  32'(done[1]));
    check({tag, " dut1.new_dendy"},    32'(new_dendy1),    32'(dendy[1]));
    check({tag, " dut1.mismatch_cnt"}, 32'(mismatch_cnt1), 32'(mism[1]));
  endtask

  task automatic step(input bit rd, input bit a13, input bit na13, input bit rm, input string tag);
    ppu_rd_in = rd; ppu_a13_in = a13; ppu_not_a13_in = na13; rearm = rm;
    @(posedge m2);
    #1;
    model_edge(rd, a13, na13, rm);
    check_all(tag);
  endtask

  // Reset is applied between edges so its asynchronous effect is checked before any edge.
  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #2;
    model_reset();
    check_all(tag);
    @(negedge m2);
    reset_n = 1'b1;
  endtask

  task automatic good_six(input bit na13_hi, input string tag);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, tag);
      step(1'b0, 1'b1, na13_hi, 1'b0, tag);
    end
  endtask

  initial begin
    #7;
    do_reset("reset");

    // Idle reads: power-on window, then the sampling timeout forces an OLD verdict.
    for (int k = 0; k < INIT_CYCLES + TIMEOUT + 4; k++) step(1'b1, 1'b0, 1'b1, 1'b0, "timeout");

    step(1'b0, 1'b0, 1'b0, 1'b1, "rearm1");
    good_six(1'b0, "clean");
    step(1'b0, 1'b1, 1'b1, 1'b0, "hold_old");

    step(1'b1, 1'b0, 1'b1, 1'b1, "rearm2");
    good_six(1'b1, "na13_stuck");

    step(1'b1, 1'b0, 1'b1, 1'b1, "rearm3");
    step(1'b0, 1'b0, 1'b1, 1'b0, "one_mis");
    step(1'b0, 1'b1, 1'b0, 1'b0, "one_mis");
    step(1'b0, 1'b0, 1'b0, 1'b0, "one_mis");
    step(1'b0, 1'b1, 1'b0, 1'b0, "one_mis");
    step(1'b0, 1'b0, 1'b1, 1'b0, "one_mis");
    step(1'b0, 1'b1, 1'b0, 1'b0, "one_mis");

    step(1'b1, 1'b0, 1'b1, 1'b1, "rearm4");
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, "all_mis");
      step(1'b0, 1'b1, 1'b1, 1'b0, "all_mis");
    end

    // Extra samples at one level keep counting mismatches up to saturation.
    step(1'b1, 1'b0, 1'b1, 1'b1, "rearm5");
    for (int k = 0; k < 17; k++) step(1'b0, 1'b0, 1'b0, 1'b0, "lo_only");
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b0, "hi_after");

    // Completion landing on the timeout edge.
    step(1'b1, 1'b0, 1'b1, 1'b1, "rearm6");
    for (int k = 0; k < TIMEOUT - 6; k++) step(1'b1, 1'b0, 1'b1, 1'b0, "late_idle");
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, "late_done");
      step(1'b0, 1'b1, 1'b1, 1'b0, "late_done");
    end

    // Reset mid-sample, then rearm held through the power-on window.
    step(1'b1, 1'b0, 1'b1, 1'b1, "rearm7");
    step(1'b0, 1'b0, 1'b0, 1'b0, "pre_reset");
    step(1'b0, 1'b1, 1'b1, 1'b0, "pre_reset");
    do_reset("mid_reset");
    for (int k = 0; k < INIT_CYCLES + 2; k++) step(1'b0, 1'b0, 1'b0, 1'b1, "rearm_init");

    // Random traffic with occasional rearm and reset.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 149) == 0) do_reset("rand_reset");
      step(1'($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom),
           1'($urandom_range(0, 39) == 0), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
